// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage handshake, redirect, loader and IF_ID bundle.
// master = fetch stage, slave = decode/branch/loader side.
interface fetch_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 128
);
  localparam int AW = $clog2(DEPTH);

  logic              stall;
  logic              branch_taken;
  logic [XLEN-1:0]   branch_target;
  logic              load_en;
  logic [AW-1:0]     load_addr;
  logic [XLEN-1:0]   load_data;
  logic [2*XLEN-1:0] IF_ID;
  logic              if_id_valid;
  logic [XLEN-1:0]   pc;
  logic              fetch_fault;

  modport master (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  load_en,
    input  load_addr,
    input  load_data,
    output IF_ID,
    output if_id_valid,
    output pc,
    output fetch_fault
  );

  modport slave (
    output stall,
    output branch_taken,
    output branch_target,
    output load_en,
    output load_addr,
    output load_data,
    input  IF_ID,
    input  if_id_valid,
    input  pc,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, loadable instruction memory and the IF_ID latch.
// Redirects squash the in-flight slot; an out-of-range PC faults stickily.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 128,
  parameter int              PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SH = $clog2(PC_STEP);

  localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(PC_STEP - 1);
  localparam logic [XLEN:0]   LIMIT = (XLEN+1)'(DEPTH);

  logic [XLEN-1:0]   mem_q [DEPTH];

  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc_d;
  logic [2*XLEN-1:0] ifid_q;
  logic [2*XLEN-1:0] ifid_d;
  logic              vld_q;
  logic              vld_d;
  logic              flt_q;
  logic              flt_d;

  logic [XLEN-1:0]   idx;
  logic [XLEN-1:0]   tgt;
  logic [XLEN-1:0]   rd_word;
  logic              in_range;

  // No reset on the array: contents survive reset
  always_ff @(posedge clock) begin
    if (bus.load_en) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  assign idx      = pc_q >> SH;
  assign in_range = {1'b0, idx} < LIMIT;
  assign rd_word  = mem_q[idx[AW-1:0]];
  assign tgt      = bus.branch_target & ALIGN;

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    vld_d  = vld_q;
    flt_d  = flt_q;
    priority case (1'b1)
      bus.branch_taken: begin
        pc_d   = tgt;
        ifid_d = '0;
        vld_d  = 1'b0;
        flt_d  = 1'b0;
      end
      flt_q: begin
        vld_d = 1'b0;
      end
      bus.stall: begin
      end
      !in_range: begin
        vld_d = 1'b0;
        flt_d = 1'b1;
      end
      default: begin
        ifid_d = {pc_q, rd_word};
        vld_d  = 1'b1;
        pc_d   = pc_q + STEP;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      ifid_q <= '0;
      vld_q  <= 1'b0;
      flt_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      vld_q  <= vld_d;
      flt_q  <= flt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.IF_ID       = ifid_q;
  assign bus.if_id_valid = vld_q;
  assign bus.fetch_fault = flt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven checks on a word-mode DEPTH=8 core plus
// a hand sequence on a byte-mode XLEN=8 core for alignment and wrap.
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  fetch_stage_if #(.XLEN(32), .DEPTH(8))  bus_a ();
  fetch_stage_if #(.XLEN(8),  .DEPTH(64)) bus_b ();

  fetch_stage #(
    .XLEN(32), .DEPTH(8), .PC_STEP(1), .RESET_PC(32'h0)
  ) dut_a (
    .clock(clk), .reset(rst_a), .bus(bus_a)
  );

  fetch_stage #(
    .XLEN(8), .DEPTH(64), .PC_STEP(4), .RESET_PC(8'h08)
  ) dut_b (
    .clock(clk), .reset(rst_b), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       nm;
    bit          rn;
    bit          st;
    bit          br;
    logic [31:0] tgt;
    bit          ld;
    logic [2:0]  la;
    logic [31:0] ldd;
    logic [31:0] e_pc;
    logic [31:0] e_ipc;
    logic [31:0] e_ins;
    bit          e_v;
    bit          e_f;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input string nm, input bit rn, st, br, input logic [31:0] tgt,
    input bit ld, input logic [2:0] la, input logic [31:0] ldd,
    input logic [31:0] e_pc, e_ipc, e_ins, input bit e_v, e_f);
    vec_t v;
    v.nm = nm; v.rn = rn; v.st = st; v.br = br; v.tgt = tgt;
    v.ld = ld; v.la = la; v.ldd = ldd;
    v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_ins = e_ins;
    v.e_v = e_v; v.e_f = e_f;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input logic [31:0] pc,
                       input logic [63:0] ifid, input bit v, f);
    chk({nm, ".pc"},    64'(bus_a.pc), 64'(pc));
    chk({nm, ".ifid"},  bus_a.IF_ID, ifid);
    chk({nm, ".valid"}, 64'(bus_a.if_id_valid), 64'(v));
    chk({nm, ".fault"}, 64'(bus_a.fetch_fault), 64'(f));
  endtask

  task automatic chk_b(input string nm, input logic [7:0] pc,
                       input logic [15:0] ifid, input bit v, f);
    chk({nm, ".pc"},    64'(bus_b.pc), 64'(pc));
    chk({nm, ".ifid"},  64'(bus_b.IF_ID), 64'(ifid));
    chk({nm, ".valid"}, 64'(bus_b.if_id_valid), 64'(v));
    chk({nm, ".fault"}, 64'(bus_b.fetch_fault), 64'(f));
  endtask

  localparam logic [31:0] IA = 32'h0AAAAAAA;
  localparam logic [31:0] IB = 32'h0BBBBBBB;
  localparam logic [31:0] IC = 32'h0CCCCCCC;
  localparam logic [31:0] ID = 32'h0DDDDDDD;
  localparam logic [31:0] IE = 32'h0EEEEEEE;
  localparam logic [31:0] IF = 32'h0FFFFFFF;
  localparam logic [31:0] I6 = 32'h11111111;
  localparam logic [31:0] I7 = 32'h22222222;
  localparam logic [31:0] IN = 32'h55555555;
  localparam logic [31:0] IR = 32'h12345678;

  logic [31:0] init_a [8];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    init_a = '{IA, IB, IC, ID, IE, IF, I6, I7};
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.stall = 0; bus_a.branch_taken = 0; bus_a.branch_target = '0;
    bus_a.load_en = 0; bus_a.load_addr = '0; bus_a.load_data = '0;
    bus_b.stall = 0; bus_b.branch_taken = 0; bus_b.branch_target = '0;
    bus_b.load_en = 0; bus_b.load_addr = '0; bus_b.load_data = '0;

    // Fill both memories while reset is held
    for (int i = 0; i < 64; i++) begin
      bus_a.load_en   = (i < 8);
      bus_a.load_addr = 3'(i);
      bus_a.load_data = init_a[i % 8];
      bus_b.load_en   = 1'b1;
      bus_b.load_addr = 6'(i);
      bus_b.load_data = 8'(8'h80 + i);
      step();
    end
    bus_a.load_en = 0;
    bus_b.load_en = 0;
    step();
    chk_a("a_reset", 32'h0, 64'h0, 0, 0);
    chk_b("b_reset", 8'h08, 16'h0, 0, 0);

    //   name       rn st br tgt        ld la ldd  pc          ipc      ins v f
    add("run0",     1, 0, 0, 32'h0,     0, 0, 0,   32'h1,      0, IA, 1, 0);
    add("run1",     1, 0, 0, 32'h0,     0, 0, 0,   32'h2,      1, IB, 1, 0);
    add("run2",     1, 0, 0, 32'h0,     0, 0, 0,   32'h3,      2, IC, 1, 0);
    add("stall0",   1, 1, 0, 32'h0,     0, 0, 0,   32'h3,      2, IC, 1, 0);
    add("stall1",   1, 1, 0, 32'h0,     0, 0, 0,   32'h3,      2, IC, 1, 0);
    add("stall2",   1, 1, 0, 32'h0,     0, 0, 0,   32'h3,      2, IC, 1, 0);
    add("unstall",  1, 0, 0, 32'h0,     0, 0, 0,   32'h4,      3, ID, 1, 0);
    add("br_stall", 1, 1, 1, 32'h1,     0, 0, 0,   32'h1,      0, 0,  0, 0);
    add("br_tgt",   1, 0, 0, 32'h0,     0, 0, 0,   32'h2,      1, IB, 1, 0);
    add("collide",  1, 0, 0, 32'h0,     1, 2, IN,  32'h3,      2, IC, 1, 0);
    add("run3",     1, 0, 0, 32'h0,     0, 0, 0,   32'h4,      3, ID, 1, 0);
    add("run4",     1, 0, 0, 32'h0,     0, 0, 0,   32'h5,      4, IE, 1, 0);
    add("run5",     1, 0, 0, 32'h0,     0, 0, 0,   32'h6,      5, IF, 1, 0);
    add("run6",     1, 0, 0, 32'h0,     0, 0, 0,   32'h7,      6, I6, 1, 0);
    add("run7",     1, 0, 0, 32'h0,     0, 0, 0,   32'h8,      7, I7, 1, 0);
    add("fault",    1, 0, 0, 32'h0,     0, 0, 0,   32'h8,      7, I7, 0, 1);
    add("f_hold",   1, 0, 0, 32'h0,     0, 0, 0,   32'h8,      7, I7, 0, 1);
    add("f_stall",  1, 1, 0, 32'h0,     0, 0, 0,   32'h8,      7, I7, 0, 1);
    add("f_clear",  1, 0, 1, 32'h0,     0, 0, 0,   32'h0,      0, 0,  0, 0);
    add("refetch",  1, 0, 0, 32'h0,     0, 0, 0,   32'h1,      0, IA, 1, 0);
    add("br_new",   1, 0, 1, 32'h2,     0, 0, 0,   32'h2,      0, 0,  0, 0);
    add("new_data", 1, 0, 0, 32'h0,     0, 0, 0,   32'h3,      2, IN, 1, 0);
    add("br_high",  1, 0, 1, 32'h100,   0, 0, 0,   32'h100,    0, 0,  0, 0);
    add("f_high",   1, 0, 0, 32'h0,     0, 0, 0,   32'h100,    0, 0,  0, 1);
    add("f_clr2",   1, 1, 1, 32'h3,     0, 0, 0,   32'h3,      0, 0,  0, 0);
    add("run8",     1, 0, 0, 32'h0,     0, 0, 0,   32'h4,      3, ID, 1, 0);
    add("rst_mix",  0, 1, 1, 32'h5,     1, 0, IR,  32'h0,      0, 0,  0, 0);
    add("rel",      1, 0, 0, 32'h0,     0, 0, 0,   32'h1,      0, IR, 1, 0);
    add("run9",     1, 0, 0, 32'h0,     0, 0, 0,   32'h2,      1, IB, 1, 0);

    foreach (vq[k]) begin
      rst_a               = vq[k].rn;
      bus_a.stall         = vq[k].st;
      bus_a.branch_taken  = vq[k].br;
      bus_a.branch_target = vq[k].tgt;
      bus_a.load_en       = vq[k].ld;
      bus_a.load_addr     = vq[k].la;
      bus_a.load_data     = vq[k].ldd;
      step();
      chk_a(vq[k].nm, vq[k].e_pc, {vq[k].e_ipc, vq[k].e_ins},
            vq[k].e_v, vq[k].e_f);
    end
    bus_a.stall = 0; bus_a.branch_taken = 0; bus_a.load_en = 0;

    // Byte mode: reset PC, alignment of target, wrap at top of space
    rst_b = 1'b1;
    step();
    chk_b("b_first", 8'h0C, {8'h08, 8'h82}, 1, 0);
    bus_b.branch_taken  = 1;
    bus_b.branch_target = 8'h13;
    step();
    chk_b("b_br13", 8'h10, 16'h0, 0, 0);
    bus_b.branch_taken = 0;
    step();
    chk_b("b_at10", 8'h14, {8'h10, 8'h84}, 1, 0);
    bus_b.branch_taken  = 1;
    bus_b.branch_target = 8'hFF;
    step();
    chk_b("b_brFF", 8'hFC, 16'h0, 0, 0);
    bus_b.branch_taken = 0;
    step();
    chk_b("b_wrap", 8'h00, {8'hFC, 8'hBF}, 1, 0);
    step();
    chk_b("b_after", 8'h04, {8'h00, 8'h80}, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
